stream_write_scheduler: RTL
===========================

# stream_write_scheduler

Sequences one SDRAM stream test run. It starts and stops the 32-bit counter stream generator and buffers its words in a small FIFO. It then issues fixed-length burst write requests to the SDRAM controller write port at consecutive addresses until a programmed number of bursts has been written. The block sits between the stream generator and the SDRAM controller.

## Interface
Parameters:
- DATA_W, 32, stream/SDRAM word width
- ADDR_W, 22, SDRAM word-address width
- BURST_LEN, 8, words per write burst (power of 2, ≥2)
- FIFO_DEPTH, 16, buffer depth (power of 2, ≥2*BURST_LEN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- start  in  1  one-cycle pulse, begins a run; ignored while busy
- base_addr  in  ADDR_W  first burst word address, sampled on accepted start
- num_bursts  in  16  bursts in the run, sampled on accepted start
- gen_enable  out  1  enable to stream generator
- gen_data  in  DATA_W  generator word
- gen_valid  in  1  one-cycle strobe, gen_data valid
- wr_req  out  1  burst write request, held until acknowledged
- wr_addr  out  ADDR_W  burst start address, stable while wr_req high
- wr_ack  in  1  one-cycle pulse, controller accepted the request
- wr_data  out  DATA_W  FIFO head word (show-ahead)
- wr_data_next  in  1  controller consumes wr_data this cycle
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at end of run
- overflow  out  1  sticky: a generator word was dropped; cleared on accepted start or rst

## Operation
- States: IDLE, FILL, REQ, XFER, FINISH.
- IDLE: on start, latch base_addr/num_bursts, clear burst index, word counters, overflow, FIFO. Go to FILL, or to FINISH if num_bursts=0.
- gen_enable is high from the cycle after the accepted start until pushed words = num_bursts*BURST_LEN. It is low in IDLE and FINISH.
- Push: gen_valid with gen_enable high pushes gen_data. If the FIFO is full and there is no pop in the same cycle, the word is dropped, overflow is set, and the pushed count still advances so the run length is preserved.
- FILL: go to REQ when FIFO count ≥ BURST_LEN.
- REQ: wr_req high. wr_addr = base_addr + burst_idx*BURST_LEN, mod 2^ADDR_W (wraps silently). On wr_ack go to XFER.
- XFER: each wr_data_next pops one word. After the BURST_LEN-th pop, burst_idx increments. Next state is FILL if burst_idx+1 < num_bursts, else FINISH. wr_data_next is ignored outside XFER or when the FIFO is empty.
- FINISH: pulse done for one cycle, go to IDLE.
- wr_data outputs the FIFO head. Its value is undefined when the FIFO is empty.
- rst: state IDLE, FIFO emptied. All outputs are 0: gen_enable, wr_req, wr_addr, busy, done, overflow. rst mid-run aborts immediately with no done pulse.

## Timing
- start sampled in cycle N: busy=1 and gen_enable=1 in N+1.
- wr_req rises the cycle after FIFO count reaches BURST_LEN.
- wr_ack in cycle M: wr_req=0 in M+1. wr_data_next is valid from M+1.
- Pop in the same cycle as wr_data_next; the next word is on wr_data in the following cycle.
- Final pop in cycle K: done=1 in K+1 (FINISH), busy=0 in K+2.
- num_bursts=0: done pulses in N+1; no wr_req, gen_enable stays 0.
- Push and pop in the same cycle: count unchanged, and the push is accepted even when full.

## Structure
- Shared package (sdram_stream_pkg): state encoding, DATA_W/ADDR_W/BURST_LEN defaults.
- Sub-module: sync_fifo (show-ahead, count output, full/empty), parameterized DATA_W/FIFO_DEPTH.
- FSM, address generator and run counters live in the top module.

## Test plan
- base_addr=0x100, num_bursts=2, gen_valid every 18 cycles, immediate ack/next -> wr_addr 0x100 then 0x108, 16 words 0..15 in order, one done pulse, overflow=0.
- num_bursts=0 -> done one cycle after start, wr_req and gen_enable never rise.
- base_addr=0x3FFFFC, num_bursts=2 -> second wr_addr=0x000004 (wrap).
- Hold wr_ack low 200 cycles with gen_valid every cycle -> FIFO fills, overflow=1, words dropped; run still ends after num_bursts bursts.
- start pulsed while busy -> ignored, latched parameters unchanged.
- rst during XFER -> next cycle busy=0, wr_req=0, gen_enable=0; no done pulse. A new start runs cleanly from an empty FIFO.

Source files
------------

// File: rtl/sdram_stream_pkg.sv
// Shared definitions for the SDRAM stream test path: scheduler state
// encoding and default widths/sizes used by the scheduler and its FIFO.
package sdram_stream_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 22;
  localparam int DEF_BURST_LEN  = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_REQ,
    S_XFER,
    S_FINISH
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. A push and a pop in the
// same cycle are both accepted even when full. clr empties the FIFO
// synchronously, exactly like rst but under the owner's control.
module sync_fifo
  import sdram_stream_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  // Pointer and occupancy update; a pop frees the slot a same-cycle push needs.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are never reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/stream_write_scheduler.sv
// Runs one stream-to-SDRAM test: enables the counter generator, buffers its
// words, and issues fixed-length burst writes at consecutive addresses
// until the requested number of bursts has been written.
module stream_write_scheduler
  import sdram_stream_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_bursts,
  output logic              gen_enable,
  input  logic [DATA_W-1:0] gen_data,
  input  logic              gen_valid,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_data_next,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int LB  = $clog2(BURST_LEN);
  localparam int CW  = 16 + LB;
  localparam int FAW = $clog2(FIFO_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       nb_q, nb_d;
  logic [15:0]       bidx_q, bidx_d;
  logic [CW-1:0]     pushed_q, pushed_d;
  logic [LB-1:0]     beat_q, beat_d;
  logic              ovf_q, ovf_d;
  logic              gen_en_q, gen_en_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;

  logic              fifo_clr;
  logic              fifo_full, fifo_empty;
  logic [FAW:0]      fifo_count;
  logic              push_evt, pop_req, gen_done, beat;
  logic [CW-1:0]     total_words;
  logic [ADDR_W-1:0] addr_off;

  assign total_words = {nb_q, {LB{1'b0}}};
  assign push_evt    = gen_valid && gen_en_q;
  assign pop_req     = wr_data_next && (state_q == S_XFER);
  assign gen_done    = (pushed_q == total_words);
  // Dropped words leave the FIFO short at the end of the run; once the
  // generator is finished an empty-FIFO beat is counted anyway (data
  // undefined) so the run still completes its programmed burst count.
  assign beat        = pop_req && (!fifo_empty || gen_done);
  assign addr_off    = ADDR_W'({bidx_q, {LB{1'b0}}});

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (push_evt),
    .din   (gen_data),
    .pop   (pop_req),
    .dout  (wr_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, run counters, address generation and output decode.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    nb_d     = nb_q;
    bidx_d   = bidx_q;
    pushed_d = pushed_q;
    beat_d   = beat_q;
    ovf_d    = ovf_q;
    gen_en_d = gen_en_q;
    req_d    = req_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    fifo_clr = 1'b0;

    if (state_q != S_IDLE) begin
      if (push_evt) begin
        pushed_d = pushed_q + CW'(1);
        if (fifo_full && !pop_req) ovf_d = 1'b1;
      end
      gen_en_d = gen_en_q && (pushed_d != total_words);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          nb_d     = num_bursts;
          bidx_d   = '0;
          pushed_d = '0;
          beat_d   = '0;
          ovf_d    = 1'b0;
          fifo_clr = 1'b1;
          if (num_bursts == '0) begin
            state_d  = S_FINISH;
            done_d   = 1'b1;
            gen_en_d = 1'b0;
          end else begin
            state_d  = S_FILL;
            gen_en_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if ((fifo_count >= (FAW+1)'(BURST_LEN)) || gen_done) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          addr_d  = base_q + addr_off;
        end
      end
      S_REQ: begin
        if (wr_ack) begin
          state_d = S_XFER;
          req_d   = 1'b0;
          beat_d  = '0;
        end
      end
      S_XFER: begin
        if (beat) begin
          if (beat_q == LB'(BURST_LEN - 1)) begin
            beat_d = '0;
            bidx_d = bidx_q + 16'd1;
            if ((bidx_q + 16'd1) < nb_q) begin
              state_d = S_FILL;
            end else begin
              state_d  = S_FINISH;
              done_d   = 1'b1;
              gen_en_d = 1'b0;
            end
          end else begin
            beat_d = beat_q + LB'(1);
          end
        end
      end
      S_FINISH: begin
        state_d  = S_IDLE;
        gen_en_d = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        gen_en_d = 1'b0;
        req_d    = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset aborts a run without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bidx_q   <= '0;
      pushed_q <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
      gen_en_q <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bidx_q   <= bidx_d;
      pushed_q <= pushed_d;
      beat_q   <= beat_d;
      ovf_q    <= ovf_d;
      gen_en_q <= gen_en_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
    end
  end

  // Run parameters latched on an accepted start; they carry no reset.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    nb_q   <= nb_d;
  end

  assign gen_enable = gen_en_q;
  assign wr_req     = req_q;
  assign wr_addr    = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign overflow   = ovf_q;

endmodule
